// File: rtl/cdb_arbiter.sv
// cdb_arbiter: completion broadcast unit between the functional units and the
// reservation stations. Each FU deposits {ROB tag, value} results into a
// small private FIFO through a valid/ready handshake. Every cycle a
// round-robin scan picks up to NUM_LANES non-empty FIFOs, pops their heads
// and drives them (registered) onto the wakeup lanes snooped by the RS.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   fu_valid/tag/value  per-FU result offer
//   fu_ready       per-FU FIFO has room (current occupancy only)
//   flush          squash everything buffered or about to broadcast
//   wakeup, wakeup_tag, wakeup_value  registered broadcast lanes
//   busy           at least one FIFO holds an entry
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int NUM_FU     = 6,
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_LANES  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_FU-1:0]                        fu_valid,
  input  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0]      fu_tag,
  input  logic [NUM_FU-1:0][`XLEN-1:0]             fu_value,
  output logic [NUM_FU-1:0]                        fu_ready,
  input  logic                                     flush,
  output logic [NUM_LANES-1:0]                     wakeup,
  output logic [NUM_LANES-1:0][`ROB_TAG_LEN-1:0]   wakeup_tag,
  output logic [NUM_LANES-1:0][`XLEN-1:0]          wakeup_value,
  output logic                                     busy
);

  localparam int TAG_W  = `ROB_TAG_LEN;
  localparam int VAL_W  = `XLEN;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [CNT_W-1:0]  count [NUM_FU];
  logic [PTR_W-1:0]  head  [NUM_FU];
  logic [PTR_W-1:0]  tail  [NUM_FU];
  logic [TAG_W-1:0]  tag_mem [NUM_FU][FIFO_DEPTH];
  logic [VAL_W-1:0]  val_mem [NUM_FU][FIFO_DEPTH];
  logic [FU_W-1:0]   rr_ptr;

  logic [NUM_FU-1:0]    push_p0;
  logic [NUM_FU-1:0]    nonempty_p0;
  logic [NUM_FU-1:0]    grant_p0;
  logic [NUM_LANES-1:0] lane_vld_p0;
  logic [FU_W-1:0]      lane_fu_p0 [NUM_LANES];
  logic [FU_W-1:0]      rr_next_p0;

  // ---- stage p0: FIFO status, handshake and arbitration on registered state
  always_comb begin
    fu_ready    = '0;
    nonempty_p0 = '0;
    push_p0     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      // Occupancy alone decides readiness: a pop in the same cycle gives no credit.
      fu_ready[i]    = (count[i] < CNT_W'(FIFO_DEPTH)) && !reset;
      nonempty_p0[i] = (count[i] != '0);
      push_p0[i]     = fu_valid[i] && fu_ready[i];
    end
    busy = |nonempty_p0;
  end

  always_comb begin
    int n;
    int idx;
    int last;
    logic [FU_W-1:0] sel;
    grant_p0    = '0;
    lane_vld_p0 = '0;
    for (int j = 0; j < NUM_LANES; j++) lane_fu_p0[j] = '0;
    rr_next_p0  = rr_ptr;
    n    = 0;
    last = 0;
    sel  = '0;
    // Scan starting at rr_ptr with wrap; grants fill lanes in scan order.
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      sel = FU_W'(idx);
      if (nonempty_p0[sel] && (n < NUM_LANES)) begin
        grant_p0[sel]                = 1'b1;
        lane_vld_p0[LANE_W'(n)]      = 1'b1;
        lane_fu_p0[LANE_W'(n)]       = sel;
        n                            = n + 1;
        last                         = idx;
      end
    end
    if (n != 0) rr_next_p0 = (last == NUM_FU - 1) ? '0 : FU_W'(last + 1);
  end

  // ---- stage p1: FIFO bookkeeping and registered broadcast lanes
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
      wakeup       <= '0;
      wakeup_tag   <= '0;
      wakeup_value <= '0;
      // A squash keeps the fairness position; only reset rewinds it.
      if (reset) rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push_p0[i])  tail[i] <= tail[i] + PTR_W'(1);
        if (grant_p0[i]) head[i] <= head[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push_p0[i]) - CNT_W'(grant_p0[i]);
      end
      rr_ptr <= rr_next_p0;
      for (int j = 0; j < NUM_LANES; j++) begin
        wakeup[j]       <= lane_vld_p0[j];
        wakeup_tag[j]   <= lane_vld_p0[j] ? tag_mem[lane_fu_p0[j]][head[lane_fu_p0[j]]] : '0;
        wakeup_value[j] <= lane_vld_p0[j] ? val_mem[lane_fu_p0[j]][head[lane_fu_p0[j]]] : '0;
      end
    end
  end

  // FIFO storage carries no reset; only the pointers/counts define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_p0[i] && !flush) begin
        tag_mem[i][tail[i]] <= fu_tag[i];
        val_mem[i][tail[i]] <= fu_value[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;
  localparam int NF = 6;
  localparam int DEPTH = 2;
  localparam int NL = 4;
  localparam int T = `ROB_TAG_LEN;
  localparam int X = `XLEN;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NF-1:0]         fu_valid = '0;
  logic [NF-1:0][T-1:0]  fu_tag = '0;
  logic [NF-1:0][X-1:0]  fu_value = '0;
  logic [NF-1:0]         fu_ready;
  logic                  flush = 1'b0;
  logic [NL-1:0]         wakeup;
  logic [NL-1:0][T-1:0]  wakeup_tag;
  logic [NL-1:0][X-1:0]  wakeup_value;
  logic                  busy;

  cdb_arbiter #(.NUM_FU(NF), .FIFO_DEPTH(DEPTH), .NUM_LANES(NL)) dut (
    .clk(clk), .reset(reset), .fu_valid(fu_valid), .fu_tag(fu_tag),
    .fu_value(fu_value), .fu_ready(fu_ready), .flush(flush), .wakeup(wakeup),
    .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [T-1:0] tag; logic [X-1:0] val; } item_t;
  typedef struct { int cyc; int lane; logic [T-1:0] tag; logic [X-1:0] val; } exp_t;

  item_t mq [NF][$];      // reference contents of each FU FIFO
  exp_t  sb [$];          // expected broadcasts, in cycle then lane order
  int    rr_m = 0;        // reference round-robin start
  bit    pend_v [NF];
  logic [T-1:0] pend_tag [NF];
  logic [X-1:0] pend_val [NF];
  int    nchecks = 0;
  int    nerrors = 0;
  bit    mon_en = 1'b0;
  logic [T-1:0] next_tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consume expectations as the lanes present broadcasts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          nchecks++; nerrors++;
          $display("FAIL missing_broadcast: tag %0h lane %0d never seen, expected in cycle %0d", e.tag, e.lane, e.cyc);
        end
        for (int j = 0; j < NL; j++) begin
          if (wakeup[j]) begin
            if (sb.size() == 0) begin
              nchecks++; nerrors++;
              $display("FAIL unexpected_broadcast: lane %0d tag %0h, expected none (cycle %0d)", j, wakeup_tag[j], cyc);
            end else begin
              e = sb.pop_front();
              chk("bcast_cycle", 64'(cyc), 64'(e.cyc));
              chk("bcast_lane", 64'(j), 64'(e.lane));
              chk("bcast_tag", 64'(wakeup_tag[j]), 64'(e.tag));
              chk("bcast_value", 64'(wakeup_value[j]), 64'(e.val));
            end
          end else begin
            chk("idle_lane_tag", 64'(wakeup_tag[j]), 64'(0));
            chk("idle_lane_value", 64'(wakeup_value[j]), 64'(0));
          end
        end
      end
    end
  end

  // One clock of stimulus plus the reference model's view of the edge.
  task automatic cycle(input bit fl);
    logic [NF-1:0] rdy;
    bit   anyb;
    int   nl;
    int   last;
    int   i;
    item_t it;
    exp_t  e;
    @(negedge clk);
    rdy = '0;
    anyb = 1'b0;
    for (int f = 0; f < NF; f++) begin
      rdy[f] = (mq[f].size() < DEPTH);
      if (mq[f].size() > 0) anyb = 1'b1;
    end
    chk("fu_ready", 64'(fu_ready), 64'(rdy));
    chk("busy", 64'(busy), 64'(anyb));
    for (int f = 0; f < NF; f++) begin
      fu_valid[f] = pend_v[f];
      fu_tag[f]   = pend_tag[f];
      fu_value[f] = pend_val[f];
    end
    flush = fl;
    if (fl) begin
      for (int f = 0; f < NF; f++) mq[f].delete();
    end else begin
      nl = 0;
      last = -1;
      for (int k = 0; k < NF; k++) begin
        i = (rr_m + k) % NF;
        if (mq[i].size() > 0 && nl < NL) begin
          it = mq[i].pop_front();
          e.cyc = cyc + 1; e.lane = nl; e.tag = it.tag; e.val = it.val;
          sb.push_back(e);
          nl++;
          last = i;
        end
      end
      if (last >= 0) rr_m = (last + 1) % NF;
    end
    for (int f = 0; f < NF; f++) begin
      if (pend_v[f] && rdy[f]) begin
        if (!fl) begin
          it.tag = pend_tag[f]; it.val = pend_val[f];
          mq[f].push_back(it);
        end
        pend_v[f] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic offer(input int f, input logic [T-1:0] tag, input logic [X-1:0] val);
    pend_v[f] = 1'b1; pend_tag[f] = tag; pend_val[f] = val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fu_valid = '0; flush = 1'b0;
    @(negedge clk);
    chk("fu_ready_in_reset", 64'(fu_ready), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    fu_valid = '0;
    for (int f = 0; f < NF; f++) begin
      mq[f].delete();
      pend_v[f] = 1'b0;
    end
    rr_m = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    for (int f = 0; f < NF; f++) begin
      pend_v[f] = 1'b0; pend_tag[f] = '0; pend_val[f] = '0;
    end
    do_reset();

    // Single result from FU2
    offer(2, T'(5), 32'hDEAD_BEEF);
    cycle(1'b0);
    idle(4);

    // Burst from all FUs after a fresh reset
    do_reset();
    for (int f = 0; f < NF; f++) offer(f, T'(10 + f), $urandom);
    cycle(1'b0);
    idle(4);

    // Per-FU ordering: FU3 tag 7 then tag 8
    offer(3, T'(7), 32'h7);
    cycle(1'b0);
    offer(3, T'(8), 32'h8);
    cycle(1'b0);
    idle(4);

    // Saturating load: every FU always offering, held until accepted
    for (int c = 0; c < 20; c++) begin
      for (int f = 0; f < NF; f++) begin
        if (!pend_v[f]) begin
          offer(f, next_tag, $urandom);
          next_tag = next_tag + 1'b1;
        end
      end
      cycle(1'b0);
    end
    idle(8);

    // Flush with five buffered results and FU1 offering tag 9 in the flush cycle
    for (int f = 0; f < 5; f++) offer(f, T'(20 + f), $urandom);
    cycle(1'b0);
    offer(1, T'(9), 32'h9);
    cycle(1'b1);
    idle(2);
    // Burst right after the flush exercises the retained round-robin position
    for (int f = 0; f < NF; f++) offer(f, T'(30 + f), $urandom);
    cycle(1'b0);
    idle(4);

    // Random mix of offers and occasional flushes
    for (int c = 0; c < 300; c++) begin
      for (int f = 0; f < NF; f++) begin
        if (!pend_v[f] && ($urandom_range(0, 1) == 1)) begin
          offer(f, T'($urandom), $urandom);
        end
      end
      cycle($urandom_range(0, 19) == 0);
    end
    idle(12);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion broadcast unit sitting between the functional units and every reservation station. Each FU posts finished results (ROB tag plus value) through a valid/ready handshake into a small per-FU FIFO. Each cycle a round-robin arbiter picks up to four buffered results and drives them, registered, onto the four wakeup lanes that reservation stations snoop to mark operands ready and capture values. It is the transmitter side of the RS `wakeup` / `wakeup_tag` / `wakeup_value` interface.

## Interface
- NUM_FU, 6, number of FU result ports.
- FIFO_DEPTH, 2, entries per FU FIFO (power of two, ≥2).
- NUM_LANES, 4, broadcast lanes. Fixed at 4 to match the RS wakeup inputs.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fu_valid  in  [NUM_FU-1:0]  FU i presents a result.
- fu_tag  in  [NUM_FU-1:0][`ROB_TAG_LEN-1:0]  ROB tag of the result.
- fu_value  in  [NUM_FU-1:0][`XLEN-1:0]  result value.
- fu_ready  out  [NUM_FU-1:0]  FIFO i can accept.
- flush  in  1  squash: discard all buffered and in-flight results.
- wakeup  out  [NUM_LANES-1:0]  lane j carries a valid broadcast (registered).
- wakeup_tag  out  [NUM_LANES-1:0][`ROB_TAG_LEN-1:0]  registered.
- wakeup_value  out  [NUM_LANES-1:0][`XLEN-1:0]  registered.
- busy  out  1  at least one FIFO is non-empty.

## Operation
- Push: when fu_valid[i] and fu_ready[i] are both high at a clock edge, {tag, value} is written to the tail of FIFO i.
- fu_ready[i] = (count[i] < FIFO_DEPTH) and !reset.
  - It depends on the current count only. A same-cycle pop gives no credit.
  - It does not depend on fu_valid.
- FIFO i pops at most one entry per cycle. Entries of one FU broadcast in push order.
- Arbitration is combinational on the registered FIFO state.
  - Scan FU indices rr_ptr, rr_ptr+1, …, wrapping mod NUM_FU.
  - Grant the first min(NUM_LANES, #non-empty) non-empty FIFOs.
  - Assign grants to lanes 0,1,2,… in scan order.
- Pops: every granted FIFO pops its head at the edge.
- rr_ptr update:
  - If at least one grant: rr_ptr ← (index of last granted FU + 1) mod NUM_FU.
  - Otherwise rr_ptr is unchanged.
- Output registers, loaded every edge:
  - wakeup[j] ← 1 for each filled lane, with the granted head's tag and value.
  - Unfilled lanes: wakeup[j] ← 0, tag ← 0, value ← 0.
- busy = OR over i of (count[i] != 0).
- No bypass: an entry pushed at edge N is first eligible for arbitration in cycle N+1.
- No duplicate-tag detection. Tag value 0 is legal.
- Flush (synchronous, takes priority over push and pop):
  - All counts, head and tail pointers ← 0.
  - wakeup ← 0; tags and values ← 0.
  - Any push in the flush cycle is discarded.
  - rr_ptr is retained.
- Reset:
  - Everything a flush clears, plus rr_ptr ← 0.
  - fu_ready is 0 while reset is high.

## Timing
- Reset values: wakeup=0, wakeup_tag=0, wakeup_value=0, busy=0.
- fu_ready = all-ones in the first cycle after reset deasserts.
- Latency: handshake at edge N → entry in FIFO during cycle N+1 → if granted, on the lanes during cycle N+2. Minimum 2 cycles.
- Each broadcast is held for exactly one cycle. The RS must sample it at the following edge.
- Throughput: up to NUM_LANES results per cycle aggregate, and 1 per FU per cycle.
- Full FIFO: fu_ready[i]=0. The FU must hold valid, tag and value stable until ready. No result is dropped or duplicated.
- Starvation bound: with all FIFOs continuously non-empty, each FU is granted at least once every ceil(NUM_FU/NUM_LANES) cycles.
- Wrap-around: FIFO pointers wrap mod FIFO_DEPTH. rr_ptr wraps mod NUM_FU.
- Flush during reset: reset governs. Flush in the same cycle as a pending grant: the grant is cancelled and no pop is observable.

## Test plan
- Reset: assert reset for 2 cycles, then release.
  - In the cycle after release: wakeup=4'b0000, busy=0, fu_ready=6'h3F.
- Single result: FU2 pushes tag 5, value 32'hDEAD_BEEF at edge 1.
  - Cycle 1: busy=1.
  - Cycle 2: wakeup=4'b0001, wakeup_tag[0]=5, wakeup_value[0]=32'hDEAD_BEEF.
  - Cycle 3: wakeup=0, busy=0.
- Burst: after reset, FU0–FU5 push tags 10–15 at the same edge.
  - Next broadcast cycle: wakeup=4'b1111, lane tags 10, 11, 12, 13.
  - Following cycle: wakeup=4'b0011, lane tags 14, 15.
  - rr_ptr ends at 0.
- Backpressure and fairness: all 6 FUs hold valid for 20 cycles with incrementing tags.
  - fu_ready deasserts on some ports.
  - Scoreboard: every accepted tag is broadcast exactly once, in per-FU order.
  - Steady state: 4 lanes per cycle; each FU granted at least every 2 cycles.
- Per-FU ordering: FU3 pushes tag 7 then tag 8 on consecutive edges.
  - Tag 7 broadcasts one cycle before tag 8; never in the same cycle.
- Flush: buffer 5 results, then assert flush with FU1 pushing tag 9 in the same cycle.
  - Next cycle: wakeup=0, busy=0, fu_ready=6'h3F.
  - Tag 9 is never broadcast.
